// File: rtl/rv_wb_pkg.sv
// rv_wb_pkg: shared types and load-type encodings for the writeback stage
package rv_wb_pkg;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_LOAD = 2'd1, WB_PC4 = 2'd2, WB_NONE = 2'd3} wb_src_e;
  typedef enum logic [1:0] {IDLE, WAIT_LOAD, COMMIT} wb_state_e;
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
endpackage

// File: rtl/wb_load_extend.sv
// wb_load_extend: selects the addressed byte/half of a load word and sign/zero-extends it
module wb_load_extend
  import rv_wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] word,
  output logic [XLEN-1:0] result
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word[{addr_lo, 3'b000} +: 8];
  assign h = addr_lo[1] ? word[16 +: 16] : word[0 +: 16];
  // anything that is not a byte or half load returns the whole word
  assign result = funct3 == F3_LB  ? {{(XLEN-8){b[7]}}, b} :
                  funct3 == F3_LBU ? {{(XLEN-8){1'b0}}, b} :
                  funct3 == F3_LH  ? {{(XLEN-16){h[15]}}, h} :
                  funct3 == F3_LHU ? {{(XLEN-16){1'b0}}, h} : word;
endmodule

// File: rtl/wb_writeback_unit.sv
// wb_writeback_unit: retires MEM instructions, waits for load data and issues one registered RF write
module wb_writeback_unit
  import rv_wb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int REG_AW       = 5,
  parameter int LOAD_TIMEOUT = 64,
  parameter int INSTRET_W    = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wb_valid_i,
  output logic                 wb_ready_o,
  input  logic [REG_AW-1:0]    wb_rd_i,
  input  logic                 wb_we_i,
  input  logic [1:0]           wb_src_i,
  input  logic [XLEN-1:0]      wb_alu_i,
  input  logic [XLEN-1:0]      wb_pc4_i,
  input  logic [2:0]           wb_funct3_i,
  input  logic [1:0]           wb_addr_lo_i,
  input  logic                 mem_rsp_valid_i,
  input  logic [XLEN-1:0]      mem_rsp_data_i,
  output logic [REG_AW-1:0]    reg_write_addr_d,
  output logic                 reg_write_en_d,
  output logic [XLEN-1:0]      writeData,
  output logic                 fwd_valid_o,
  output logic [REG_AW-1:0]    fwd_addr_o,
  output logic [XLEN-1:0]      fwd_data_o,
  output logic                 load_timeout_o,
  output logic [INSTRET_W-1:0] instret_o
);
  localparam int CW = $clog2(LOAD_TIMEOUT + 1);
  wb_state_e         state, state_nx;
  logic [REG_AW-1:0] rd_q, wr_rd;
  logic              we_q, accept, rsp, expire, commit_in, wr;
  logic [2:0]        f3_q;
  logic [1:0]        alo_q;
  logic [CW-1:0]     cnt;
  logic [XLEN-1:0]   ld_data, wr_data;
  wb_load_extend #(.XLEN(XLEN)) u_ext (
    .funct3(f3_q), .addr_lo(alo_q), .word(mem_rsp_data_i), .result(ld_data)
  );
  assign wb_ready_o = state == IDLE;
  assign accept     = wb_valid_i & wb_ready_o;
  assign rsp        = state == WAIT_LOAD & mem_rsp_valid_i;
  assign expire     = state == WAIT_LOAD & ~mem_rsp_valid_i & cnt == CW'(LOAD_TIMEOUT - 1);
  // a write is issued on the edge that enters COMMIT, so the pulse coincides with COMMIT
  assign commit_in  = (accept & wb_src_i != WB_LOAD) | rsp;
  assign wr_rd      = rsp ? rd_q : wb_rd_i;
  assign wr_data    = rsp ? ld_data : (wb_src_i == WB_PC4 ? wb_pc4_i : wb_alu_i);
  assign wr         = commit_in & |wr_rd & (rsp ? we_q : wb_we_i & wb_src_i != WB_NONE);
  assign fwd_valid_o = reg_write_en_d;
  assign fwd_addr_o  = reg_write_addr_d;
  assign fwd_data_o  = writeData;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:      if (accept) state_nx = wb_src_i == WB_LOAD ? WAIT_LOAD : COMMIT;
      WAIT_LOAD: state_nx = rsp ? COMMIT : (expire ? IDLE : WAIT_LOAD);
      default:   state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      reg_write_en_d   <= 1'b0;
      reg_write_addr_d <= '0;
      writeData        <= '0;
      rd_q             <= '0;
      we_q             <= 1'b0;
      f3_q             <= '0;
      alo_q            <= '0;
      cnt              <= '0;
      instret_o        <= '0;
      load_timeout_o   <= 1'b0;
    end else begin
      reg_write_en_d <= wr;
      if (wr) begin
        reg_write_addr_d <= wr_rd;
        writeData        <= wr_data;
      end
      if (accept) begin
        rd_q  <= wb_rd_i;
        we_q  <= wb_we_i;
        f3_q  <= wb_funct3_i;
        alo_q <= wb_addr_lo_i;
      end
      cnt            <= accept ? '0 : (state == WAIT_LOAD ? cnt + CW'(1) : cnt);
      instret_o      <= instret_o + INSTRET_W'(commit_in);
      load_timeout_o <= load_timeout_o | expire;
    end
endmodule

// File: tb/tb_wb_writeback_unit.sv
// tb_wb_writeback_unit: table vectors, corner sequences and random transactions against a transaction-level model
module tb_wb_writeback_unit;
  logic        clk = 0, rst_n = 0;
  logic        wb_valid_i = 0, wb_ready_o, wb_we_i = 0, mem_rsp_valid_i = 0;
  logic [4:0]  wb_rd_i = 0, reg_write_addr_d, fwd_addr_o;
  logic [1:0]  wb_src_i = 0, wb_addr_lo_i = 0;
  logic [31:0] wb_alu_i = 0, wb_pc4_i = 0, mem_rsp_data_i = 0, writeData, fwd_data_o;
  logic [2:0]  wb_funct3_i = 0;
  logic        reg_write_en_d, fwd_valid_o, load_timeout_o;
  logic [63:0] instret_o;

  wb_writeback_unit dut (
    .clk(clk), .rst_n(rst_n), .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
    .wb_rd_i(wb_rd_i), .wb_we_i(wb_we_i), .wb_src_i(wb_src_i), .wb_alu_i(wb_alu_i),
    .wb_pc4_i(wb_pc4_i), .wb_funct3_i(wb_funct3_i), .wb_addr_lo_i(wb_addr_lo_i),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rsp_data_i(mem_rsp_data_i),
    .reg_write_addr_d(reg_write_addr_d), .reg_write_en_d(reg_write_en_d), .writeData(writeData),
    .fwd_valid_o(fwd_valid_o), .fwd_addr_o(fwd_addr_o), .fwd_data_o(fwd_data_o),
    .load_timeout_o(load_timeout_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] alu, pc4;
    logic [2:0]  f3;
    logic [1:0]  alo;
    logic [31:0] word;
    int          delay;
    logic        exp_en;
    logic [31:0] exp_data;
  } vec_t;

  int checks = 0, failures = 0, pulse_cnt = 0, ready_low = 0, cyc = 0;
  int pulse_cyc[$];
  logic [4:0]  exp_addr = 0;
  logic [31:0] exp_data = 0;
  logic [63:0] exp_instret = 0;
  vec_t tab[13];

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", n, a, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ext_ref(logic [2:0] f3, logic [1:0] alo, logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * alo)) % 256;
    h = (w >> (16 * (alo / 2))) % 65536;
    case (f3)
      3'd0:    return b < 128 ? b : b + 32'hFFFF_FF00;
      3'd4:    return b;
      3'd1:    return h < 32768 ? h : h + 32'hFFFF_0000;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) if (rst_n) begin
    if (!wb_ready_o) ready_low++;
    chk("fwd_valid", fwd_valid_o, reg_write_en_d);
    if (reg_write_en_d) begin
      pulse_cnt++;
      pulse_cyc.push_back(cyc);
      chk("fwd_addr", fwd_addr_o, reg_write_addr_d);
      chk("fwd_data", fwd_data_o, writeData);
    end
  end

  task automatic wait_ready(input string n);
    int g = 0;
    while (!wb_ready_o && g < 200) begin
      step();
      g++;
    end
    chk({n, "_ready"}, wb_ready_o, 1);
  endtask

  task automatic run_txn(input vec_t v, input logic early, input string n);
    int p0, r0;
    wait_ready(n);
    wb_src_i = v.src; wb_rd_i = v.rd; wb_we_i = v.we; wb_alu_i = v.alu; wb_pc4_i = v.pc4;
    wb_funct3_i = v.f3; wb_addr_lo_i = v.alo; wb_valid_i = 1;
    if (early) begin
      mem_rsp_valid_i = 1;
      mem_rsp_data_i = ~v.word;
    end
    p0 = pulse_cnt; r0 = ready_low;
    step();
    wb_valid_i = 0; mem_rsp_valid_i = 0;
    if (v.src == 2'd1) begin
      repeat (v.delay) step();
      mem_rsp_valid_i = 1; mem_rsp_data_i = v.word;
      step();
      mem_rsp_valid_i = 0; mem_rsp_data_i = $urandom;
    end
    step();
    exp_instret++;
    if (v.exp_en) begin
      exp_addr = v.rd;
      exp_data = v.exp_data;
    end
    chk({n, "_pulses"}, pulse_cnt - p0, v.exp_en);
    chk({n, "_addr"}, reg_write_addr_d, exp_addr);
    chk({n, "_data"}, writeData, exp_data);
    chk({n, "_instret"}, instret_o, exp_instret);
    chk({n, "_ready_low"}, ready_low - r0, v.src == 2'd1 ? v.delay + 2 : 1);
  endtask

  initial begin
    vec_t v;
    int p0, n0;
    tab[0]  = '{2'd0, 5'd5,  1, 32'h1234_5678, 0, 3'd0, 2'd0, 0, 0, 1, 32'h1234_5678};
    tab[1]  = '{2'd1, 5'd6,  1, 0, 0, 3'b000, 2'd3, 32'h80FF_0000, 2, 1, 32'hFFFF_FF80};
    tab[2]  = '{2'd1, 5'd7,  1, 0, 0, 3'b100, 2'd3, 32'h80FF_0000, 1, 1, 32'h0000_0080};
    tab[3]  = '{2'd1, 5'd8,  1, 0, 0, 3'b001, 2'd2, 32'h8001_7FFF, 0, 1, 32'hFFFF_8001};
    tab[4]  = '{2'd1, 5'd9,  1, 0, 0, 3'b101, 2'd0, 32'h8001_7FFF, 3, 1, 32'h0000_7FFF};
    tab[5]  = '{2'd0, 5'd0,  1, 32'hDEAD_BEEF, 0, 3'd0, 2'd0, 0, 0, 0, 0};
    tab[6]  = '{2'd2, 5'd10, 0, 0, 32'h44, 3'd0, 2'd0, 0, 0, 0, 0};
    tab[7]  = '{2'd2, 5'd11, 1, 32'h99, 32'h100, 3'd0, 2'd0, 0, 0, 1, 32'h100};
    tab[8]  = '{2'd3, 5'd12, 1, 32'h55, 32'h66, 3'd0, 2'd0, 0, 0, 0, 0};
    tab[9]  = '{2'd1, 5'd13, 1, 0, 0, 3'b011, 2'd1, 32'hCAFE_BABE, 0, 1, 32'hCAFE_BABE};
    tab[10] = '{2'd1, 5'd14, 1, 0, 0, 3'b010, 2'd1, 32'h1234_5678, 4, 1, 32'h1234_5678};
    tab[11] = '{2'd1, 5'd15, 1, 0, 0, 3'b000, 2'd1, 32'h0000_7F00, 0, 1, 32'h0000_007F};
    tab[12] = '{2'd1, 5'd0,  1, 0, 0, 3'b010, 2'd0, 32'h0000_0001, 1, 0, 0};

    repeat (3) step();
    chk("rst_ready", wb_ready_o, 1);
    chk("rst_en", reg_write_en_d, 0);
    chk("rst_addr", reg_write_addr_d, 0);
    chk("rst_data", writeData, 0);
    chk("rst_fwd", {fwd_valid_o, fwd_addr_o, fwd_data_o}, 0);
    chk("rst_timeout", load_timeout_o, 0);
    chk("rst_instret", instret_o, 0);
    rst_n = 1;
    step();

    for (int i = 0; i < 13; i++) run_txn(tab[i], i % 3 == 2, $sformatf("vec%0d", i));

    wait_ready("b2b");
    pulse_cyc.delete();
    wb_src_i = 2'd0; wb_we_i = 1; wb_valid_i = 1;
    for (int i = 1; i <= 4; i++) begin
      wb_rd_i = 5'(i);
      wb_alu_i = 32'h100 + i;
      for (int g = 0; g < 10 && !wb_ready_o; g++) step();
      step();
    end
    wb_valid_i = 0;
    step();
    step();
    exp_instret += 4; exp_addr = 4; exp_data = 32'h104;
    chk("b2b_count", pulse_cyc.size(), 4);
    for (int i = 1; i < pulse_cyc.size(); i++) chk($sformatf("b2b_gap%0d", i), pulse_cyc[i] - pulse_cyc[i-1], 2);
    chk("b2b_addr", reg_write_addr_d, exp_addr);
    chk("b2b_data", writeData, exp_data);
    chk("b2b_instret", instret_o, exp_instret);

    wait_ready("tmo");
    wb_src_i = 2'd1; wb_rd_i = 7; wb_we_i = 1; wb_funct3_i = 3'b010; wb_valid_i = 1;
    p0 = pulse_cnt;
    step();
    wb_valid_i = 0;
    repeat (63) step();
    chk("tmo_ready_early", wb_ready_o, 0);
    chk("tmo_flag_early", load_timeout_o, 0);
    step();
    chk("tmo_ready", wb_ready_o, 1);
    chk("tmo_flag", load_timeout_o, 1);
    mem_rsp_valid_i = 1; mem_rsp_data_i = 32'hABCD_0123;
    step();
    mem_rsp_valid_i = 0;
    step();
    chk("tmo_pulses", pulse_cnt - p0, 0);
    chk("tmo_instret", instret_o, exp_instret);
    chk("tmo_data", writeData, exp_data);

    for (int i = 0; i < 40; i++) begin
      v.src = 2'($urandom_range(0, 3)); v.rd = 5'($urandom); v.we = 1'($urandom);
      v.alu = $urandom; v.pc4 = $urandom; v.f3 = 3'($urandom); v.alo = 2'($urandom);
      v.word = $urandom; v.delay = $urandom_range(0, 4);
      v.exp_en = v.we && v.rd != 0 && v.src != 2'd3;
      v.exp_data = v.src == 2'd0 ? v.alu : v.src == 2'd2 ? v.pc4 : ext_ref(v.f3, v.alo, v.word);
      run_txn(v, 1'($urandom), $sformatf("rnd%0d", i));
    end
    chk("tmo_sticky", load_timeout_o, 1);

    wait_ready("rstw");
    wb_src_i = 2'd1; wb_rd_i = 9; wb_we_i = 1; wb_valid_i = 1;
    step();
    wb_valid_i = 0;
    step();
    step();
    n0 = pulse_cnt;
    rst_n = 0;
    #1;
    chk("rstw_ready", wb_ready_o, 1);
    chk("rstw_instret", instret_o, 0);
    chk("rstw_flag", load_timeout_o, 0);
    step();
    rst_n = 1;
    mem_rsp_valid_i = 1; mem_rsp_data_i = 32'h7777_7777;
    step();
    mem_rsp_valid_i = 0;
    step();
    chk("rstw_pulses", pulse_cnt - n0, 0);
    chk("rstw_data", writeData, 0);
    chk("rstw_instret_after", instret_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
